pri_arbiter_n: RTL and testbench

Parametrised, registered successor to the 8-to-3 priority encoder. It takes an N-bit request vector, selects one winner (fixed highest-index priority or round-robin), and holds the winner's index and one-hot grant until the requester acknowledges. It sits between request sources and a shared resource, and replaces ad-hoc combinational encoders wherever a stable, handshaked grant is needed.

---
 rtl/pri_arbiter_n_if.sv | 25 ++
 rtl/pri_arbiter_n.sv | 102 ++++++++++
 tb/tb_pri_arbiter_n.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pri_arbiter_n_if.sv
// Request/grant bundle for pri_arbiter_n. The requester side is the master
// (drives en, req, ack); the arbiter is the slave (drives the grant outputs).
interface pri_arbiter_n_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         en;
    logic [N-1:0] req;
    logic         ack;
    logic [W-1:0] y;
    logic [N-1:0] gnt;
    logic         idc;
    logic [15:0]  gnt_cnt;

    modport master (
        output en, req, ack,
        input  y, gnt, idc, gnt_cnt
    );

    modport slave (
        input  en, req, ack,
        output y, gnt, idc, gnt_cnt
    );
endinterface

// File: rtl/pri_arbiter_n.sv
// Registered N-way arbiter with handshaked grant.
// MODE 0: fixed priority, highest index wins.
// MODE 1: round-robin; ptr holds the last released winner, which gets the
//         lowest priority on the next search.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | no grant held; arbitrate when en=1 and any req is set
// BUSY  | grant held and frozen until ack (release) or en=0 (abort)
module pri_arbiter_n #(
    parameter int N    = 8,
    parameter int MODE = 0
) (
    input logic              clk,
    input logic              rst_n,
    pri_arbiter_n_if.slave   bus
);
    localparam int W = $clog2(N);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]   state;
    logic [W-1:0] ptr;
    logic [W-1:0] y_q;
    logic [N-1:0] gnt_q;
    logic         idc_q;
    logic [15:0]  cnt_q;

    logic [W-1:0] win_any;
    logic [W-1:0] win_lo;
    logic         lo_found;
    logic [W-1:0] win;

    // Search order ptr-1 .. 0, N-1 .. ptr is the same as "highest requester
    // below ptr, otherwise highest requester overall". This wraps modulo N
    // for free, and with ptr=0 it reduces to plain highest-index priority.
    always_comb begin
        win_any  = '0;
        win_lo   = '0;
        lo_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.req[i]) begin
                win_any = W'(i);
                if (W'(i) < ptr) begin
                    win_lo   = W'(i);
                    lo_found = 1'b1;
                end
            end
        end
        win = lo_found ? win_lo : win_any;
    end

    // Grant FSM, output registers, round-robin pointer and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            y_q   <= '0;
            gnt_q <= '0;
            idc_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en && (|bus.req)) begin
                        state <= BUSY;
                        y_q   <= win;
                        gnt_q <= N'(1) << win;
                        idc_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (!bus.en) begin
                        state <= IDLE;
                        y_q   <= '0;
                        gnt_q <= '0;
                        idc_q <= 1'b0;
                    end else if (bus.ack) begin
                        state <= IDLE;
                        y_q   <= '0;
                        gnt_q <= '0;
                        idc_q <= 1'b0;
                        cnt_q <= cnt_q + 16'd1;
                        if (MODE == 1) begin
                            ptr <= y_q;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.y       = y_q;
    assign bus.gnt     = gnt_q;
    assign bus.idc     = idc_q;
    assign bus.gnt_cnt = cnt_q;

endmodule

// File: tb/tb_pri_arbiter_n.sv
// Directed bench for pri_arbiter_n: three instances (MODE0/N=8, MODE1/N=8,
// MODE1/N=5) share clock and reset; sel picks which one the stimulus drives
// and which one the checks observe.
module tb_pri_arbiter_n;
    logic clk;
    logic rst_n;
    int   sel;
    logic       en_t;
    logic [7:0] req_t;
    logic       ack_t;

    int n_checks;
    int n_fail;
    int exp_cnt;

    pri_arbiter_n_if #(.N(8)) if_a ();
    pri_arbiter_n_if #(.N(8)) if_b ();
    pri_arbiter_n_if #(.N(5)) if_c ();

    pri_arbiter_n #(.N(8), .MODE(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    pri_arbiter_n #(.N(8), .MODE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    pri_arbiter_n #(.N(5), .MODE(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    assign if_a.en  = en_t && (sel == 0);
    assign if_a.req = req_t;
    assign if_a.ack = ack_t && (sel == 0);
    assign if_b.en  = en_t && (sel == 1);
    assign if_b.req = req_t;
    assign if_b.ack = ack_t && (sel == 1);
    assign if_c.en  = en_t && (sel == 2);
    assign if_c.req = req_t[4:0];
    assign if_c.ack = ack_t && (sel == 2);

    logic [31:0] obs_y, obs_gnt, obs_idc, obs_cnt;

    always_comb begin
        obs_y   = 32'(if_a.y);
        obs_gnt = 32'(if_a.gnt);
        obs_idc = 32'(if_a.idc);
        obs_cnt = 32'(if_a.gnt_cnt);
        if (sel == 1) begin
            obs_y   = 32'(if_b.y);
            obs_gnt = 32'(if_b.gnt);
            obs_idc = 32'(if_b.idc);
            obs_cnt = 32'(if_b.gnt_cnt);
        end else if (sel == 2) begin
            obs_y   = 32'(if_c.y);
            obs_gnt = 32'(if_c.gnt);
            obs_idc = 32'(if_c.idc);
            obs_cnt = 32'(if_c.gnt_cnt);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (sel=%0d, t=%0t)", tag, obs, exp, sel, $time);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_y"}, obs_y, 32'd0);
        check_val({tag, "_gnt"}, obs_gnt, 32'd0);
        check_val({tag, "_idc"}, obs_idc, 32'd0);
        check_val({tag, "_cnt"}, obs_cnt, 32'(exp_cnt));
    endtask

    task automatic check_grant(input string tag, input int exp_y);
        check_val({tag, "_y"}, obs_y, 32'(exp_y));
        check_val({tag, "_gnt"}, obs_gnt, 32'd1 << exp_y);
        check_val({tag, "_idc"}, obs_idc, 32'd1);
    endtask

    // One grant (edge after IDLE) followed by an immediate ack release.
    task automatic grant_cycle(input string tag, input int exp_y);
        step();
        check_grant(tag, exp_y);
        ack_t = 1'b1;
        step();
        ack_t = 1'b0;
        exp_cnt++;
        check_idle({tag, "_rel"});
    endtask

    int seq_b[14] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6, 5, 4, 3, 2};
    int seq_c[6]  = '{4, 3, 2, 1, 0, 4};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        sel      = 0;
        en_t     = 1'b0;
        req_t    = '0;
        ack_t    = 1'b0;
        rst_n    = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- MODE 0 ----
        check_idle("a_reset");
        en_t  = 1'b1;
        req_t = 8'b0010_0110;
        step();
        check_grant("a_first", 5);
        for (int i = 0; i < 10; i++) begin
            step();
            check_grant("a_hold", 5);
        end
        req_t = 8'h80;
        step();
        check_grant("a_req_change", 5);
        ack_t = 1'b1;
        step();
        ack_t = 1'b0;
        exp_cnt++;
        check_idle("a_release");

        req_t = 8'hFF;
        for (int i = 0; i < 3; i++) grant_cycle("a_ff", 7);

        en_t  = 1'b0;
        ack_t = 1'b1;
        step();
        ack_t = 1'b0;
        check_idle("a_ack_idle");

        // ---- MODE 1, N=8 ----
        sel     = 1;
        exp_cnt = 0;
        en_t    = 1'b1;
        req_t   = 8'hFF;
        for (int i = 0; i < 14; i++) grant_cycle("b_rr", seq_b[i]);
        req_t = 8'b0000_1001;
        grant_cycle("b_sparse0", 0);
        grant_cycle("b_sparse3", 3);

        // Reset between clock edges while BUSY.
        req_t = 8'hFF;
        step();
        check_grant("b_pre_rst", 2);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check_idle("b_async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        req_t = 8'h81;
        grant_cycle("b_post_rst", 7);

        // Abort with winner 6: ptr and counter unchanged.
        req_t = 8'hFF;
        step();
        check_grant("b_pre_abort", 6);
        en_t = 1'b0;
        step();
        check_idle("b_abort");
        en_t = 1'b1;
        grant_cycle("b_after_abort", 6);

        // ---- MODE 1, N=5 ----
        sel     = 2;
        exp_cnt = 0;
        en_t    = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en_t  = 1'b1;
        req_t = 8'h1F;
        for (int i = 0; i < 6; i++) grant_cycle("c_rr", seq_c[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
